// File: rtl/decode_issue_queue.sv
// decode_issue_queue: DEPTH-entry fetch FIFO feeding a registered RV32I decode/issue stage.
// Ports: clock/reset (async, active-high), flush (sync discard of queue and issue stage);
//   in_valid/in_ready/in_instr/in_pc form the fetch push side, in_ready = queue not full;
//   issue_valid/issue_ready hand the registered decode (op_type, op_sub, op_flag, rs1, rs2, rd,
//   use_rs1, use_rs2, wr_rd, imm, pc_out, instr_out) to the ROB; count = occupied queue entries.
// Option DECODE_ILLEGAL_TRAP_EN: adds output illegal and keeps the raw opcode in op_type.
module decode_issue_queue #(
  parameter int XLEN  = 32,
  parameter int DEPTH = 4,
  parameter int PTRW  = $clog2(DEPTH)
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_instr,
  input  logic [XLEN-1:0] in_pc,
  output logic            issue_valid,
  input  logic            issue_ready,
  output logic [6:0]      op_type,
  output logic [2:0]      op_sub,
  output logic            op_flag,
  output logic [4:0]      rs1,
  output logic [4:0]      rs2,
  output logic [4:0]      rd,
  output logic            use_rs1,
  output logic            use_rs2,
  output logic            wr_rd,
  output logic [XLEN-1:0] imm,
  output logic [XLEN-1:0] pc_out,
  output logic [31:0]     instr_out,
  output logic [PTRW:0]   count
`ifdef DECODE_ILLEGAL_TRAP_EN
  ,
  output logic            illegal
`endif
);
  typedef struct packed {
    logic [6:0]      op_type;
    logic [2:0]      op_sub;
    logic            op_flag;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [4:0]      rd;
    logic            use_rs1;
    logic            use_rs2;
    logic            wr_rd;
    logic [XLEN-1:0] imm;
    logic [XLEN-1:0] pc;
    logic [31:0]     instr;
`ifdef DECODE_ILLEGAL_TRAP_EN
    logic            illegal;
`endif
  } dec_t;
  logic [31:0]     instr_q [DEPTH];
  logic [XLEN-1:0] pc_q [DEPTH];
  logic [PTRW-1:0] head_q, tail_q;
  logic [PTRW:0]   count_q;
  logic            valid_q;
  dec_t            iss_q, dec_d;
  logic [31:0]     hi, imm32;
  logic            push, pop, use1, use2, has_rd, known;
  assign in_ready = count_q != (PTRW+1)'(DEPTH);
  assign push     = in_valid & in_ready & ~flush;
  // the issue stage refills whenever it is empty or being drained this cycle
  assign pop      = (count_q != '0) & (~valid_q | issue_ready) & ~flush;
  assign hi       = instr_q[head_q];
  always_comb begin
    dec_d         = '0;
    dec_d.op_type = hi[6:0];
    dec_d.op_sub  = 3'b111;
    dec_d.op_flag = 1'b1;
    dec_d.pc      = pc_q[head_q];
    dec_d.instr   = hi;
    imm32         = '0;
    use1          = 1'b0;
    use2          = 1'b0;
    has_rd        = 1'b0;
    known         = 1'b1;
    case (hi[6:0])
      7'b0110111, 7'b0010111: begin
        has_rd = 1'b1;
        imm32  = {hi[31:12], 12'b0};
      end
      7'b1101111: begin
        has_rd = 1'b1;
        imm32  = {{11{hi[31]}}, hi[31], hi[19:12], hi[20], hi[30:21], 1'b0};
      end
      7'b1100111, 7'b0000011: begin
        has_rd        = 1'b1;
        use1          = 1'b1;
        dec_d.op_sub  = hi[14:12];
        dec_d.op_flag = 1'b0;
        imm32         = {{20{hi[31]}}, hi[31:20]};
      end
      7'b1100011: begin
        use1         = 1'b1;
        use2         = 1'b1;
        dec_d.op_sub = hi[14:12];
        imm32        = {{19{hi[31]}}, hi[31], hi[7], hi[30:25], hi[11:8], 1'b0};
      end
      7'b0100011: begin
        use1         = 1'b1;
        use2         = 1'b1;
        dec_d.op_sub = hi[14:12];
        imm32        = {{20{hi[31]}}, hi[31:25], hi[11:7]};
      end
      7'b0010011: begin
        has_rd        = 1'b1;
        use1          = 1'b1;
        dec_d.op_sub  = hi[14:12];
        // SLLI/SRLI/SRAI carry a shamt, with instr[30] selecting arithmetic shift
        dec_d.op_flag = hi[13:12] == 2'b01 ? hi[30] : 1'b0;
        imm32         = hi[13:12] == 2'b01 ? {27'b0, hi[24:20]} : {{20{hi[31]}}, hi[31:20]};
      end
      7'b0110011: begin
        has_rd        = 1'b1;
        use1          = 1'b1;
        use2          = 1'b1;
        dec_d.op_sub  = hi[14:12];
        dec_d.op_flag = hi[30];
      end
      7'b0001111: begin
        dec_d.op_sub = hi[14:12];
        imm32        = {24'b0, hi[27:20]};
      end
      default: known = 1'b0;
    endcase
    dec_d.use_rs1 = use1;
    dec_d.use_rs2 = use2;
    dec_d.rs1     = use1 ? hi[19:15] : '0;
    dec_d.rs2     = use2 ? hi[24:20] : '0;
    dec_d.rd      = has_rd ? hi[11:7] : '0;
    dec_d.wr_rd   = has_rd & (hi[11:7] != '0);
    dec_d.imm     = XLEN'($signed(imm32)) + (hi[6:0] == 7'b0010111 ? dec_d.pc : '0);
`ifdef DECODE_ILLEGAL_TRAP_EN
    dec_d.illegal = ~known;
`else
    dec_d.op_type = known ? hi[6:0] : 7'h7F;
`endif
  end
  always_ff @(posedge clock) begin
    if (push) begin
      instr_q[tail_q] <= in_instr;
      pc_q[tail_q]    <= in_pc;
    end
  end
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      valid_q <= 1'b0;
      iss_q   <= '0;
    end else if (flush) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      valid_q <= 1'b0;
    end else begin
      if (push) tail_q <= tail_q + PTRW'(1);
      if (pop) begin
        head_q <= head_q + PTRW'(1);
        iss_q  <= dec_d;
      end
      count_q <= count_q + (PTRW+1)'(push) - (PTRW+1)'(pop);
      valid_q <= pop | (valid_q & ~issue_ready);
    end
  end
  assign issue_valid = valid_q;
  assign count       = count_q;
  assign op_type     = iss_q.op_type;
  assign op_sub      = iss_q.op_sub;
  assign op_flag     = iss_q.op_flag;
  assign rs1         = iss_q.rs1;
  assign rs2         = iss_q.rs2;
  assign rd          = iss_q.rd;
  assign use_rs1     = iss_q.use_rs1;
  assign use_rs2     = iss_q.use_rs2;
  assign wr_rd       = iss_q.wr_rd;
  assign imm         = iss_q.imm;
  assign pc_out      = iss_q.pc;
  assign instr_out   = iss_q.instr;
`ifdef DECODE_ILLEGAL_TRAP_EN
  assign illegal     = iss_q.illegal;
`endif
endmodule
